rx_uart_param: RTL and testbench

RX_UART_PARAM -- requirements
Module: rx_uart_param

---
 rtl/rx_uart_param.sv | 160 ++++++++++++++++
 tb/tb_rx_uart_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rx_uart_param.sv
// Parameterised UART receiver: 2-flop synchronised rx, mid-bit sampling, held-word handshake.
// Define RX_UART_PARITY_EN to add a parity bit (sense set by PARITY_ODD) and drive parity_err.
module rx_uart_param #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

`ifdef RX_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic                  rx_p0, rx_p1, rx_prev;
  logic [CNT_W-1:0]      cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  frame_acc_q;
  logic                  done_q;
  logic                  fall;
  logic                  tick;
  logic                  load;

  assign fall = rx_prev & ~rx_p1;
  assign tick = (cnt_q == CNT_LAST);
  assign load = done_q & (~rx_valid | rx_ack);

  // Synchronizer stage boundary: rx_p1 is the only view of the line used below
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (cnt_q == CNT_HALF) state_d = rx_p1 ? IDLE : DATA;
`ifdef RX_UART_PARITY_EN
      DATA:   if (tick && bit_cnt_q == DATA_LAST) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
      DATA:   if (tick && bit_cnt_q == DATA_LAST) state_d = STOP;
`endif
      STOP:   if (tick && bit_cnt_q == STOP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state_q != IDLE);
  end

  // Bit-timing stage boundary: counters, shifter and stop-bit accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_acc_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    cnt_q <= '0;
        START:   cnt_q <= (cnt_q == CNT_HALF) ? '0 : cnt_q + 1'b1;
        default: cnt_q <= tick ? '0 : cnt_q + 1'b1;
      endcase

      if (state_d != state_q)
        bit_cnt_q <= '0;
      else if (tick && (state_q == DATA || state_q == STOP))
        bit_cnt_q <= bit_cnt_q + 1'b1;

      if (state_q == DATA && tick)
        shift_q <= {rx_p1, shift_q[DATA_BITS-1:1]};

      if (state_q == IDLE && fall)
        frame_acc_q <= 1'b0;
      else if (state_q == STOP && tick && !rx_p1)
        frame_acc_q <= 1'b1;

      done_q <= (state_q == STOP) && (state_d == IDLE);
    end
  end

  // Output stage boundary: held word, valid handshake and overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_valid && rx_ack)
        overrun_err <= 1'b0;
      if (load) begin
        rx_data   <= shift_q;
        frame_err <= frame_acc_q;
        rx_valid  <= 1'b1;
      end else if (done_q) begin
        overrun_err <= 1'b1;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef RX_UART_PARITY_EN
  logic par_acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state_q == PARITY && tick)
        par_acc_q <= ((^shift_q) ^ rx_p1) != PARITY_ODD[0];
      if (load)
        parity_err <= par_acc_q;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart_param.sv
// Directed bench for rx_uart_param at CLK_DIV=16, 8 data bits, 1 stop bit.
module tb_rx_uart_param;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  int         checks = 0;
  int         errors = 0;
`ifdef RX_UART_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  rx_uart_param #(
    .CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ack(rx_ack), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic line_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef RX_UART_PARITY_EN
    line_bit((^d) ^ par_flip);
`endif
    line_bit(stop);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!rx_valid && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx_valid, 1);
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_frame", frame_err, 0);
    chk("rst_parity", parity_err, 0);
    chk("rst_overrun", overrun_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    ack();
    chk("ack_idle_valid", rx_valid, 0);

    // Clean frame, held until acknowledged
    send(8'hA5, 1'b1);
    wait_valid("a5_valid");
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_frame", frame_err, 0);
    chk("a5_parity", parity_err, 0);
    chk("a5_overrun", overrun_err, 0);
    chk("a5_busy", rx_busy, 0);
    repeat (20) @(negedge clk);
    chk("a5_hold_valid", rx_valid, 1);
    chk("a5_hold_data", rx_data, 8'hA5);
    ack();
    chk("a5_ack_valid", rx_valid, 0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_start", rx_busy, 1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_end", rx_busy, 0);
    chk("glitch_valid", rx_valid, 0);

    // Broken stop bit, then a good frame
    send(8'h3C, 1'b0);
    line_bit(1'b1);
    wait_valid("3c_valid");
    chk("3c_data", rx_data, 8'h3C);
    chk("3c_frame", frame_err, 1);
    ack();
    send(8'h55, 1'b1);
    wait_valid("55_valid");
    chk("55_data", rx_data, 8'h55);
    chk("55_frame", frame_err, 0);
    ack();

`ifdef RX_UART_PARITY_EN
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    wait_valid("07_bad_valid");
    chk("07_bad_parity", parity_err, 1);
    ack();
    par_flip = 1'b0;
    send(8'h07, 1'b1);
    wait_valid("07_good_valid");
    chk("07_good_parity", parity_err, 0);
    ack();
`endif

    // Back-to-back frames without acknowledge
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    line_bit(1'b1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", overrun_err, 1);
    ack();
    chk("ovr_ack_valid", rx_valid, 0);
    chk("ovr_ack_flag", overrun_err, 0);

    // Reset in the middle of the data bits
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    line_bit(1'b1);
    chk("mid_busy", rx_busy, 1);
    rst = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", rx_busy, 0);
    repeat (12 * DIV) @(negedge clk);
    chk("mid_no_valid", rx_valid, 0);
    send(8'h81, 1'b1);
    wait_valid("81_valid");
    chk("81_data", rx_data, 8'h81);
    chk("81_frame", frame_err, 0);
    chk("81_parity", parity_err, 0);
    chk("81_overrun", overrun_err, 0);
    ack();
    chk("81_ack_valid", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
